// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and its datapath.
// Latency: none (wires only).
// Backpressure: memory stalls are signalled on mem_ready_i; the controller holds mem_req_o until it arrives.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode_i;
    logic             zero_i;
    logic             mem_ready_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic             iord_o;
    logic             ir_write_o;
    logic             pc_write_o;
    logic             pc_src_o;
    logic [1:0]       alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       ALUOp_o;
    logic             reg_write_o;
    logic             mem_to_reg_o;
    logic [CNT_W-1:0] instret_o;
    logic             trap_o;
    logic [3:0]       state_o;

    // Controller side
    modport master (
        input  opcode_i, zero_i, mem_ready_i,
        output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, ALUOp_o, reg_write_o, mem_to_reg_o,
               instret_o, trap_o, state_o
    );

    // Datapath side
    modport slave (
        output opcode_i, zero_i, mem_ready_i,
        input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, ALUOp_o, reg_write_o, mem_to_reg_o,
               instret_o, trap_o, state_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RISC-V core: decodes opcode, steers shared ALU/memory, counts retirements.
// Latency: R/I 4, ld 5, sd 4, beq 3 cycles plus one per memory wait cycle; outputs combinational from state.
// Backpressure: memory states hold mem_req_o until mem_ready_i; TIMEOUT wait cycles without ready trap.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] instret;
    logic             retire;
    logic             mem_wait;
    logic             timed_out;

    // A cycle with an outstanding request and no ready counts toward the timeout.
    assign mem_wait  = bus.mem_req_o && !bus.mem_ready_i;
    // This cycle is the TIMEOUT-th without ready; ready in this same cycle still wins.
    assign timed_out = (to_cnt == TO_LAST);

    assign bus.instret_o = instret;
    assign bus.state_o   = state;
    assign bus.trap_o    = (state == TRAP);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= FETCH;
        else       state <= state_nxt;
    end

    // Wait-cycle counter; any non-waiting cycle clears it, so each memory state is entered with 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         to_cnt <= '0;
        else if (mem_wait) to_cnt <= to_cnt + 1'b1;
        else               to_cnt <= '0;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       instret <= '0;
        else if (retire) instret <= instret + 1'b1;
    end

    // Next-state and control outputs; ir_write/pc_write are qualified by ready/zero
    always_comb begin
        state_nxt        = state;
        retire           = 1'b0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.iord_o       = 1'b0;
        bus.ir_write_o   = 1'b0;
        bus.pc_write_o   = 1'b0;
        bus.pc_src_o     = 1'b0;
        bus.alu_src_a_o  = 2'b00;
        bus.alu_src_b_o  = 2'b00;
        bus.ALUOp_o      = 2'b00;
        bus.reg_write_o  = 1'b0;
        bus.mem_to_reg_o = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_req_o   = 1'b1;
                bus.alu_src_b_o = 2'b01;
                if (bus.mem_ready_i) begin
                    bus.ir_write_o = 1'b1;
                    bus.pc_write_o = 1'b1;
                    state_nxt      = DECODE;
                end else if (timed_out) begin
                    state_nxt = TRAP;
                end
            end
            DECODE: begin
                // Branch target computed speculatively into ALUOut
                bus.alu_src_a_o = 2'b10;
                bus.alu_src_b_o = 2'b10;
                case (bus.opcode_i)
                    OP_R:         state_nxt = EXEC_R;
                    OP_I:         state_nxt = EXEC_I;
                    OP_LD, OP_SD: state_nxt = MEM_ADDR;
                    OP_BR:        state_nxt = BRANCH;
                    default:      state_nxt = TRAP;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a_o = 2'b01;
                bus.alu_src_b_o = 2'b10;
                state_nxt = (bus.opcode_i == OP_LD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.mem_req_o = 1'b1;
                bus.iord_o    = 1'b1;
                if (bus.mem_ready_i) state_nxt = MEM_WB;
                else if (timed_out)  state_nxt = TRAP;
            end
            MEM_WB: begin
                bus.reg_write_o  = 1'b1;
                bus.mem_to_reg_o = 1'b1;
                retire           = 1'b1;
                state_nxt        = FETCH;
            end
            MEM_WR: begin
                bus.mem_req_o = 1'b1;
                bus.mem_we_o  = 1'b1;
                bus.iord_o    = 1'b1;
                if (bus.mem_ready_i) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else if (timed_out) begin
                    state_nxt = TRAP;
                end
            end
            EXEC_R: begin
                bus.alu_src_a_o = 2'b01;
                bus.ALUOp_o     = 2'b10;
                state_nxt       = ALU_WB;
            end
            EXEC_I: begin
                bus.alu_src_a_o = 2'b01;
                bus.alu_src_b_o = 2'b10;
                bus.ALUOp_o     = 2'b11;
                state_nxt       = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_write_o = 1'b1;
                retire          = 1'b1;
                state_nxt       = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a_o = 2'b01;
                bus.ALUOp_o     = 2'b01;
                bus.pc_write_o  = bus.zero_i;
                bus.pc_src_o    = 1'b1;
                retire          = 1'b1;
                state_nxt       = FETCH;
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                // Unused encodings are treated as a fault
                state_nxt = TRAP;
            end
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-state control vectors, cycle counts, timeout, trap, counter wrap.
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
// Memory ready is driven per cycle from small stimulus tables.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    // {req, we, iord, irw, pcw, pcsrc, srcA[2], srcB[2], aluop[2], regw, m2r}
    localparam logic [13:0] O_F  = 14'b1_0_0_0_0_0_00_01_00_0_0;
    localparam logic [13:0] O_FR = 14'b1_0_0_1_1_0_00_01_00_0_0;
    localparam logic [13:0] O_D  = 14'b0_0_0_0_0_0_10_10_00_0_0;
    localparam logic [13:0] O_MA = 14'b0_0_0_0_0_0_01_10_00_0_0;
    localparam logic [13:0] O_MR = 14'b1_0_1_0_0_0_00_00_00_0_0;
    localparam logic [13:0] O_WB = 14'b0_0_0_0_0_0_00_00_00_1_1;
    localparam logic [13:0] O_MW = 14'b1_1_1_0_0_0_00_00_00_0_0;
    localparam logic [13:0] O_ER = 14'b0_0_0_0_0_0_01_00_10_0_0;
    localparam logic [13:0] O_EI = 14'b0_0_0_0_0_0_01_10_11_0_0;
    localparam logic [13:0] O_AW = 14'b0_0_0_0_0_0_00_00_00_1_0;
    localparam logic [13:0] O_BT = 14'b0_0_0_0_1_1_01_00_01_0_0;
    localparam logic [13:0] O_BN = 14'b0_0_0_0_0_1_01_00_01_0_0;
    localparam logic [13:0] O_Z  = 14'b0;

    logic       clk;
    logic       rst;
    int         n_pass;
    int         n_total;
    logic [3:0] exp_cnt;

    multicycle_ctrl_if #(.CNT_W(4)) bus ();

    multicycle_ctrl #(.CNT_W(4), .TIMEOUT(15)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] outs();
        return {bus.mem_req_o, bus.mem_we_o, bus.iord_o, bus.ir_write_o, bus.pc_write_o,
                bus.pc_src_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.ALUOp_o,
                bus.reg_write_o, bus.mem_to_reg_o};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode_i = 7'd0; bus.zero_i = 1'b0; bus.mem_ready_i = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.state_o !== 4'd0) $display("FAIL reset_state got %0d exp 0", bus.state_o); else n_pass++;
        n_total++; if (outs() !== O_F) $display("FAIL reset_outs got %b exp %b", outs(), O_F); else n_pass++;
        n_total++; if (bus.instret_o !== 4'd0) $display("FAIL reset_instret got %0d exp 0", bus.instret_o); else n_pass++;
        n_total++; if (bus.trap_o !== 1'b0) $display("FAIL reset_trap got %b exp 0", bus.trap_o); else n_pass++;
        rst = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_add();
        logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd6, 4'd8};
        logic [13:0] ex[4] = '{O_FR, O_D, O_ER, O_AW};
        bus.opcode_i = OP_R; bus.mem_ready_i = 1'b1; bus.zero_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (bus.state_o !== st[i]) $display("FAIL add_state[%0d] got %0d exp %0d", i, bus.state_o, st[i]); else n_pass++;
            n_total++; if (outs() !== ex[i]) $display("FAIL add_outs[%0d] got %b exp %b", i, outs(), ex[i]); else n_pass++;
            if (i == 3) begin
                n_total++; if (bus.instret_o !== exp_cnt) $display("FAIL add_instret_pre got %0d exp %0d", bus.instret_o, exp_cnt); else n_pass++;
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_total++; if (bus.state_o !== 4'd0) $display("FAIL add_end_state got %0d exp 0", bus.state_o); else n_pass++;
        n_total++; if (bus.instret_o !== exp_cnt) $display("FAIL add_instret got %0d exp %0d", bus.instret_o, exp_cnt); else n_pass++;
    endtask

    task automatic test_ld_wait();
        logic        rdy[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  st[8]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [13:0] ex[8]  = '{O_FR, O_D, O_MA, O_MR, O_MR, O_MR, O_MR, O_WB};
        bus.opcode_i = OP_LD; bus.zero_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready_i = rdy[i];
            #1;
            n_total++; if (bus.state_o !== st[i]) $display("FAIL ld_state[%0d] got %0d exp %0d", i, bus.state_o, st[i]); else n_pass++;
            n_total++; if (outs() !== ex[i]) $display("FAIL ld_outs[%0d] got %b exp %b", i, outs(), ex[i]); else n_pass++;
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_total++; if (bus.state_o !== 4'd0) $display("FAIL ld_end_state got %0d exp 0", bus.state_o); else n_pass++;
        n_total++; if (bus.instret_o !== exp_cnt) $display("FAIL ld_instret got %0d exp %0d", bus.instret_o, exp_cnt); else n_pass++;
    endtask

    task automatic test_beq();
        logic [3:0] st[3] = '{4'd0, 4'd1, 4'd9};
        for (int t = 1; t >= 0; t--) begin
            logic [13:0] ex[3];
            ex[0] = O_FR; ex[1] = O_D; ex[2] = (t == 1) ? O_BT : O_BN;
            bus.opcode_i = OP_BR; bus.zero_i = (t == 1);
            for (int i = 0; i < 3; i++) begin
                bus.mem_ready_i = (i == 0);
                #1;
                n_total++; if (bus.state_o !== st[i]) $display("FAIL beq%0d_state[%0d] got %0d exp %0d", t, i, bus.state_o, st[i]); else n_pass++;
                n_total++; if (outs() !== ex[i]) $display("FAIL beq%0d_outs[%0d] got %b exp %b", t, i, outs(), ex[i]); else n_pass++;
                @(posedge clk); #1;
            end
            exp_cnt++;
            n_total++; if (bus.state_o !== 4'd0) $display("FAIL beq%0d_end_state got %0d exp 0", t, bus.state_o); else n_pass++;
            n_total++; if (bus.instret_o !== exp_cnt) $display("FAIL beq%0d_instret got %0d exp %0d", t, bus.instret_o, exp_cnt); else n_pass++;
        end
        bus.zero_i = 1'b0;
    endtask

    task automatic test_trap();
        bus.opcode_i = OP_XX; bus.mem_ready_i = 1'b1;
        #1;
        @(posedge clk); #1;
        n_total++; if (bus.state_o !== 4'd1) $display("FAIL trap_decode got %0d exp 1", bus.state_o); else n_pass++;
        @(posedge clk); #1;
        // Inputs that would otherwise advance the FSM must be ignored
        bus.opcode_i = OP_R; bus.zero_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (bus.state_o !== 4'd10) $display("FAIL trap_state[%0d] got %0d exp 10", i, bus.state_o); else n_pass++;
            n_total++; if (bus.trap_o !== 1'b1) $display("FAIL trap_flag[%0d] got %b exp 1", i, bus.trap_o); else n_pass++;
            n_total++; if (outs() !== O_Z) $display("FAIL trap_outs[%0d] got %b exp %b", i, outs(), O_Z); else n_pass++;
            n_total++; if (bus.instret_o !== exp_cnt) $display("FAIL trap_instret[%0d] got %0d exp %0d", i, bus.instret_o, exp_cnt); else n_pass++;
            @(posedge clk); #1;
        end
        bus.zero_i = 1'b0; bus.mem_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        n_total++; if (bus.state_o !== 4'd0) $display("FAIL trap_rst_state got %0d exp 0", bus.state_o); else n_pass++;
        n_total++; if (bus.trap_o !== 1'b0) $display("FAIL trap_rst_flag got %b exp 0", bus.trap_o); else n_pass++;
        n_total++; if (bus.instret_o !== 4'd0) $display("FAIL trap_rst_instret got %0d exp 0", bus.instret_o); else n_pass++;
        #1;
        rst = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic test_timeout();
        // Run 0: no ready ever -> trap after 15 request cycles. Run 1: ready on cycle 15 -> DECODE.
        bus.opcode_i = OP_R;
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 15; c++) begin
                bus.mem_ready_i = (r == 1) && (c == 15);
                #1;
                n_total++; if (bus.state_o !== 4'd0) $display("FAIL to%0d_wait[%0d] got %0d exp 0", r, c, bus.state_o); else n_pass++;
                @(posedge clk); #1;
            end
            bus.mem_ready_i = 1'b0;
            #1;
            n_total++;
            if (bus.state_o !== ((r == 0) ? 4'd10 : 4'd1))
                $display("FAIL to%0d_after got %0d exp %0d", r, bus.state_o, (r == 0) ? 10 : 1);
            else n_pass++;
            n_total++; if (bus.trap_o !== (r == 0)) $display("FAIL to%0d_trap got %b exp %b", r, bus.trap_o, (r == 0)); else n_pass++;
            rst = 1'b1; #1; rst = 1'b0;
            exp_cnt = 4'd0;
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd7, 4'd8};
        logic [13:0] ex[4] = '{O_FR, O_D, O_EI, O_AW};
        bus.opcode_i = OP_I; bus.mem_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                #1;
                if (k == 0) begin
                    n_total++; if (bus.state_o !== st[i]) $display("FAIL addi_state[%0d] got %0d exp %0d", i, bus.state_o, st[i]); else n_pass++;
                    n_total++; if (outs() !== ex[i]) $display("FAIL addi_outs[%0d] got %b exp %b", i, outs(), ex[i]); else n_pass++;
                end
                @(posedge clk); #0;
            end
            exp_cnt++;
            #1;
            n_total++; if (bus.instret_o !== exp_cnt) $display("FAIL wrap_instret[%0d] got %0d exp %0d", k, bus.instret_o, exp_cnt); else n_pass++;
            if (k == 14) begin
                n_total++; if (bus.instret_o !== 4'd15) $display("FAIL wrap_max got %0d exp 15", bus.instret_o); else n_pass++;
            end
        end
        n_total++; if (bus.instret_o !== 4'd0) $display("FAIL wrap_zero got %0d exp 0", bus.instret_o); else n_pass++;
    endtask

    task automatic test_sd();
        logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [13:0] ex[4] = '{O_FR, O_D, O_MA, O_MW};
        bus.opcode_i = OP_SD; bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (bus.state_o !== st[i]) $display("FAIL sd_state[%0d] got %0d exp %0d", i, bus.state_o, st[i]); else n_pass++;
            n_total++; if (outs() !== ex[i]) $display("FAIL sd_outs[%0d] got %b exp %b", i, outs(), ex[i]); else n_pass++;
            @(posedge clk); #1;
        end
        exp_cnt++;
        n_total++; if (bus.state_o !== 4'd0) $display("FAIL sd_end_state got %0d exp 0", bus.state_o); else n_pass++;
        n_total++; if (bus.instret_o !== exp_cnt) $display("FAIL sd_instret got %0d exp %0d", bus.instret_o, exp_cnt); else n_pass++;
    endtask

    task automatic test_rst_mid_wr();
        bus.opcode_i = OP_SD;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready_i = (i == 0);
            #1;
            @(posedge clk); #1;
        end
        bus.mem_ready_i = 1'b0;
        #1;
        n_total++; if (bus.state_o !== 4'd5) $display("FAIL wr_state got %0d exp 5", bus.state_o); else n_pass++;
        n_total++; if (bus.mem_we_o !== 1'b1) $display("FAIL wr_we got %b exp 1", bus.mem_we_o); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (bus.mem_we_o !== 1'b0) $display("FAIL wr_rst_we got %b exp 0", bus.mem_we_o); else n_pass++;
        n_total++; if (bus.state_o !== 4'd0) $display("FAIL wr_rst_state got %0d exp 0", bus.state_o); else n_pass++;
        n_total++; if (outs() !== O_F) $display("FAIL wr_rst_outs got %b exp %b", outs(), O_F); else n_pass++;
        n_total++; if (bus.instret_o !== 4'd0) $display("FAIL wr_rst_instret got %0d exp 0", bus.instret_o); else n_pass++;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_cnt = 4'd0;
        test_reset();
        test_add();
        test_ld_wait();
        test_beq();
        test_trap();
        test_timeout();
        test_wrap();
        test_sd();
        test_rst_mid_wr();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main sequencing FSM for the multi-cycle variant of the RISC-V core. One shared ALU and one unified memory port are time-multiplexed across instruction phases.
- Decodes opcode and drives ALU source muxes, register-file and memory enables, and the 2-bit ALUOp that feeds the ALU control decoder.
- Encodings: ALUOp 00=add (ld/sd/address), 01=sub (beq), 10=R-type funct decode, 11=addi.
- Also counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).
- TIMEOUT, 15, maximum cycles to wait for mem_ready_i per memory access before trapping (>=1).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- opcode_i  in  7  instr[6:0] from instruction register
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes current request this cycle
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  write qualifier for mem_req_o
- iord_o  out  1  memory address source: 0=PC, 1=ALUOut
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  load PC
- pc_src_o  out  1  PC source: 0=ALU result, 1=ALUOut register
- alu_src_a_o  out  2  00=PC, 01=rs1, 10=oldPC
- alu_src_b_o  out  2  00=rs2, 01=constant 4, 10=imm
- ALUOp_o  out  2  to ALU control
- reg_write_o  out  1  register-file write enable
- mem_to_reg_o  out  1  writeback source: 0=ALUOut, 1=MDR
- instret_o  out  CNT_W  retired-instruction count
- trap_o  out  1  sticky error flag
- state_o  out  4  current state encoding (debug)

Behaviour:
- Reset (async, any state, including mid-access): state=FETCH, instret_o=0, trap_o=0, internal timeout counter=0. All outputs 0 except the FETCH Moore outputs: mem_req_o=1, alu_src_b_o=01.
- Outputs not listed for a state are 0. ir_write_o and pc_write_o are Mealy, qualified by mem_ready_i/zero_i as stated.
- State encodings:
  - FETCH(0): mem_req_o=1, iord_o=0, src_a=00, src_b=01, ALUOp=00. When mem_ready_i=1, pulse ir_write_o=1 and pc_write_o=1 (pc_src 0), then -> DECODE.
  - DECODE(1): src_a=10, src_b=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 / 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - else -> TRAP
  - MEM_ADDR(2): src_a=01, src_b=10, ALUOp=00. ld -> MEM_RD; sd -> MEM_WR.
  - MEM_RD(3): mem_req_o=1, iord_o=1. mem_ready_i -> MEM_WB.
  - MEM_WB(4): reg_write_o=1, mem_to_reg_o=1 -> FETCH; retire.
  - MEM_WR(5): mem_req_o=1, mem_we_o=1, iord_o=1. mem_ready_i -> FETCH; retire on ready.
  - EXEC_R(6): src_a=01, src_b=00, ALUOp=10 -> ALU_WB.
  - EXEC_I(7): src_a=01, src_b=10, ALUOp=11 -> ALU_WB.
  - ALU_WB(8): reg_write_o=1 -> FETCH; retire.
  - BRANCH(9): src_a=01, src_b=00, ALUOp=01. pc_write_o=zero_i, pc_src_o=1 -> FETCH; retire regardless of taken/not taken.
  - TRAP(10): trap_o=1, all enables 0. Absorbing until rst_i.
- Cycle counts:
  - R/I-type: 4 cycles (zero-wait memory).
  - ld: 5 cycles.
  - sd: 4 cycles.
  - beq: 3 cycles.
  - Each memory wait cycle adds 1.
- Timeout: counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_req_o=1 and mem_ready_i=0. Reaching TIMEOUT with no ready -> TRAP next cycle. mem_ready_i on the TIMEOUT-th cycle wins over the timeout.
- mem_ready_i is ignored in states with mem_req_o=0.
- instret_o increments by 1 in the retire cycle and wraps from all-ones to 0. It is frozen in TRAP.
- Retire and trap never coincide.

Test Plan:
- add (opcode 0110011), mem_ready_i tied 1 → states 0,1,6,8,0. ALUOp_o=10 in EXEC_R, reg_write_o=1 one cycle, instret_o 0→1.
- ld with mem_ready_i delayed 3 cycles in MEM_RD → mem_req_o/iord_o held 1 for 4 cycles, MEM_WB with mem_to_reg_o=1. Total 8 cycles, instret_o=1.
- beq zero_i=1 vs zero_i=0 → BRANCH ALUOp_o=01. pc_write_o=1 & pc_src_o=1 only when taken. Both retire.
- opcode 1111111 → DECODE→TRAP, trap_o=1 sticky. Further mem_ready_i/opcode ignored, instret_o frozen. rst_i mid-TRAP → FETCH, trap_o=0 asynchronously.
- TIMEOUT=15, mem_ready_i held 0 in FETCH → TRAP after 15 request cycles. A repeat run with ready on cycle 15 → DECODE, no trap.
- CNT_W=4, 16 addi retirements → instret_o wraps 15→0. Assert rst_i asynchronously mid-MEM_WR → mem_we_o drops immediately, state_o=0.
